// File: rtl/stream_source_x.sv
// Buffers one LENX-sample vector from the load port, then replays it num_reps times on the x port.
// First sample is valid two cycles after start; the skid register absorbs backpressure without loss.
module stream_source_x #(
  parameter int WIDTH = 16,
  parameter int LENX  = 8,
  parameter int ADDRX = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in_ld,
  input  logic                    s_valid_ld,
  output logic                    s_ready_ld,
  input  logic                    start,
  input  logic [7:0]              num_reps,
  output logic signed [WIDTH-1:0] m_data_out_x,
  output logic                    m_valid_x,
  input  logic                    m_ready_x,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {LOAD, ARMED, SEND, FIN} state_t;

  localparam logic [ADDRX-1:0] ADDR_LAST = ADDRX'(LENX - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0] mem [LENX];
  logic [ADDRX-1:0] wr_addr, rd_addr;
  logic [7:0]       rep_cnt;

  logic             rd_vld;
  logic [WIDTH-1:0] rd_dat;
  logic             out_vld;
  logic [WIDTH-1:0] out_dat;
  logic             skid_vld;
  logic [WIDTH-1:0] skid_dat;

  logic ld_fire, in_rdy, rd_issue, rd_adv, rd_wrap, out_xfer, last_xfer;

  assign ld_fire   = s_valid_ld && (state == LOAD);
  assign in_rdy    = !skid_vld;
  assign rd_issue  = (state == SEND) && (rep_cnt != 8'd0) && (!rd_vld || in_rdy);
  assign rd_adv    = rd_vld && in_rdy;
  assign rd_wrap   = (rd_addr == ADDR_LAST);
  assign out_xfer  = out_vld && m_ready_x;
  // Nothing left to read and nothing queued behind the output register.
  assign last_xfer = out_xfer && (rep_cnt == 8'd0) && !rd_vld && !skid_vld;

  assign m_valid_x    = out_vld;
  assign m_data_out_x = out_dat;

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    s_ready_ld = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      LOAD: begin
        s_ready_ld = 1'b1;
        if (s_valid_ld && (wr_addr == ADDR_LAST)) state_nxt = ARMED;
      end
      ARMED: begin
        if (start) state_nxt = SEND;
      end
      SEND: begin
        busy = 1'b1;
        if (last_xfer) state_nxt = FIN;
      end
      FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Buffer array: not reset, contents persist across vectors.
  always_ff @(posedge clk) begin
    if (!reset && ld_fire) mem[wr_addr] <= s_data_in_ld;
    if (rd_issue)          rd_dat <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      rep_cnt  <= 8'd0;
      rd_vld   <= 1'b0;
      out_vld  <= 1'b0;
      out_dat  <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
    end else begin
      if (state == FIN)
        wr_addr <= '0;
      else if (ld_fire)
        wr_addr <= (wr_addr == ADDR_LAST) ? '0 : wr_addr + 1'b1;

      if ((state == ARMED) && start) begin
        rep_cnt <= (num_reps == 8'd0) ? 8'd1 : num_reps;
        rd_addr <= '0;
      end else if (rd_issue) begin
        rd_addr <= rd_wrap ? '0 : rd_addr + 1'b1;
        if (rd_wrap) rep_cnt <= rep_cnt - 8'd1;
      end

      if (rd_issue)    rd_vld <= 1'b1;
      else if (rd_adv) rd_vld <= 1'b0;

      // Output register refills from skid first; a stalled output parks the read stage in skid.
      if (!out_vld || m_ready_x) begin
        if (skid_vld) begin
          out_vld  <= 1'b1;
          out_dat  <= skid_dat;
          skid_vld <= 1'b0;
        end else begin
          out_vld <= rd_vld;
          if (rd_vld) out_dat <= rd_dat;
        end
      end else if (rd_adv) begin
        skid_vld <= 1'b1;
        skid_dat <= rd_dat;
      end
    end
  end

endmodule

// File: doc/stream_source_x.md
STREAM_SOURCE_X -- requirements
Module: stream_source_x

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width in bits.
REQ-002 SHALL have parameter LENX, default 8, samples per vector (2..2**ADDRX).
REQ-003 SHALL have parameter ADDRX, default 3, buffer address width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 s_data_in_ld  input  WIDTH  signed load sample.
REQ-007 s_valid_ld  input  1  load sample valid.
REQ-008 s_ready_ld  output  1  block accepts load sample.
REQ-009 start  input  1  request transmission of buffered vector.
REQ-010 num_reps  input  8  vector repetitions, sampled with start; 0 treated as 1.
REQ-011 m_data_out_x  output  WIDTH  signed transmitted sample.
REQ-012 m_valid_x  output  1  m_data_out_x valid.
REQ-013 m_ready_x  input  1  downstream (convolver x port) accepts sample.
REQ-014 busy  output  1  high in any state except LOAD and ARMED.
REQ-015 done  output  1  one-cycle pulse after final sample transferred.

Function
REQ-016 SHALL implement FSM states LOAD, ARMED, SEND, FIN.
REQ-017 LOAD: s_ready_ld=1; each cycle with s_valid_ld&&s_ready_ld writes sample to buffer[wr_addr], wr_addr increments.
REQ-018 LOAD->ARMED on the write of sample LENX-1; s_ready_ld SHALL be 0 the following cycle.
REQ-019 ARMED: s_ready_ld=0; start==1 captures num_reps (0->1) into rep counter, rd_addr=0, state->SEND.
REQ-020 start SHALL be ignored in LOAD, SEND, FIN; s_valid_ld SHALL be ignored outside LOAD.
REQ-021 Buffer SHALL be synchronous-read, one-cycle latency, with one output register plus one skid register so no sample is lost or duplicated under backpressure.
REQ-022 Latency: start sampled at edge N -> m_valid_x=1 with buffer[0] after edge N+2.
REQ-023 Handshake: transfer occurs on edge where m_valid_x&&m_ready_x; while m_valid_x=1 and m_ready_x=0, m_data_out_x and m_valid_x SHALL remain stable.
REQ-024 m_valid_x SHALL never deassert without a transfer.
REQ-025 With m_ready_x held 1, SHALL sustain one transfer per cycle, no bubbles, including across repetition boundaries.
REQ-026 Sample order per repetition: buffer[0]..buffer[LENX-1]; rd_addr wraps LENX-1->0 and rep counter decrements at wrap.
REQ-027 Total transfers per start SHALL equal LENX*max(num_reps,1).
REQ-028 SEND->FIN on final transfer; in FIN, done=1 for exactly one cycle, m_valid_x=0, then FIN->LOAD with wr_addr=0.
REQ-029 Buffer contents SHALL persist across vectors; only overwritten by new LOAD writes.
REQ-030 Data SHALL be passed bit-exact; no arithmetic on samples.
REQ-031 Counters: wr_addr, rd_addr ADDRX bits; rep counter 8 bits; no overflow beyond defined wrap.

Reset
REQ-032 reset=1 at an edge SHALL set state=LOAD, wr_addr=0, rd_addr=0, rep counter=0, skid/output registers invalid.
REQ-033 Outputs after reset: s_ready_ld=1, m_valid_x=0, m_data_out_x=0, busy=0, done=0.
REQ-034 Reset mid-SEND SHALL abort transmission immediately; no further transfers; buffer contents need not be cleared.
REQ-035 reset SHALL override s_valid_ld, start, m_ready_x in the same cycle.

Verification
REQ-036 Load 1..8 (LENX=8), start, num_reps=1, m_ready_x=1 -> m_valid_x after 2 cycles, outputs 1..8 on 8 consecutive cycles, done pulse 1 cycle after 8th, s_ready_ld=1 next cycle.
REQ-037 Same load, m_ready_x toggled 1,0,0,1 pattern -> exactly 8 transfers 1..8 in order, data stable during every stall.
REQ-038 num_reps=3, m_ready_x=1 -> 24 back-to-back transfers 1..8,1..8,1..8, single done pulse.
REQ-039 num_reps=0 -> behaves as 1: 8 transfers; start asserted in LOAD and during SEND -> ignored, no extra transfers.
REQ-040 Reset asserted after 3rd transfer -> next cycle m_valid_x=0, s_ready_ld=1, busy=0; new load of -1..-8 and start -> outputs -1..-8.
REQ-041 s_valid_ld held 1 after 8th write -> 9th sample not written (s_ready_ld=0), buffer[0] remains first sample.
